// File: rtl/rx_frame_buffer.sv
// Purpose: buffers good UART RX frames in a FWFT FIFO, tracks overrun and saturating parity/stop error counts.
// Latency: a good frame shows on RD_DATA one cycle after its valid rising edge when the FIFO was empty.
// Backpressure: none toward the receiver; a frame arriving into a full FIFO without a same-cycle pop is dropped and flagged.
module rx_frame_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_DATA_VALID,
    input  logic                      RX_PAR_ERR,
    input  logic                      RX_STOP_ERR,
    input  logic                      RD_EN,
    input  logic                      CLR_ERR,
    output logic [DATA_WIDTH-1:0]     RD_DATA,
    output logic                      RD_VALID,
    output logic                      FIFO_FULL,
    output logic [$clog2(DEPTH):0]    FIFO_COUNT,
    output logic                      OVERRUN,
    output logic [CNT_WIDTH-1:0]      PAR_ERR_CNT,
    output logic [CNT_WIDTH-1:0]      STOP_ERR_CNT
);

    localparam int                   PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]       FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  prev_vld;
    logic                  prev_par;
    logic                  prev_stop;
    logic                  overrun_q;
    logic [CNT_WIDTH-1:0]  par_cnt;
    logic [CNT_WIDTH-1:0]  stop_cnt;

    logic frame_evt;
    logic good_frame;
    logic par_rise;
    logic stop_rise;
    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign frame_evt  = RX_DATA_VALID & ~prev_vld;
    assign good_frame = frame_evt & ~RX_PAR_ERR & ~RX_STOP_ERR;
    assign par_rise   = RX_PAR_ERR & ~prev_par;
    assign stop_rise  = RX_STOP_ERR & ~prev_stop;

    assign not_empty  = (count != '0);
    assign full       = (count == FULL_CNT);
    assign pop        = RD_EN & not_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = good_frame & (~full | pop);
    assign drop       = good_frame & full & ~pop;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_vld  <= 1'b0;
            prev_par  <= 1'b0;
            prev_stop <= 1'b0;
        end else begin
            prev_vld  <= RX_DATA_VALID;
            prev_par  <= RX_PAR_ERR;
            prev_stop <= RX_STOP_ERR;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; reads are masked by not_empty instead.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= RX_P_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (CLR_ERR) begin
            overrun_q <= 1'b0;
        end
    end

    // A rising error edge coincident with a clear leaves the counter at one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_cnt  <= '0;
            stop_cnt <= '0;
        end else begin
            if (par_rise) begin
                if (CLR_ERR) begin
                    par_cnt <= CNT_WIDTH'(1);
                end else if (par_cnt != CNT_MAX) begin
                    par_cnt <= par_cnt + CNT_WIDTH'(1);
                end
            end else if (CLR_ERR) begin
                par_cnt <= '0;
            end

            if (stop_rise) begin
                if (CLR_ERR) begin
                    stop_cnt <= CNT_WIDTH'(1);
                end else if (stop_cnt != CNT_MAX) begin
                    stop_cnt <= stop_cnt + CNT_WIDTH'(1);
                end
            end else if (CLR_ERR) begin
                stop_cnt <= '0;
            end
        end
    end

    assign RD_DATA      = not_empty ? mem[rd_ptr] : '0;
    assign RD_VALID     = not_empty;
    assign FIFO_FULL    = full;
    assign FIFO_COUNT   = count;
    assign OVERRUN      = overrun_q;
    assign PAR_ERR_CNT  = par_cnt;
    assign STOP_ERR_CNT = stop_cnt;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed and randomized bench for rx_frame_buffer against a queue-based reference model.
module tb_rx_frame_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] rx_data;
    logic          rx_vld;
    logic          rx_par;
    logic          rx_stop;
    logic          rd_en;
    logic          clr_err;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          fifo_full;
    logic [3:0]    fifo_count;
    logic          overrun;
    logic [CW-1:0] par_cnt;
    logic [CW-1:0] stop_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    bit            m_ovr;
    int            m_par;
    int            m_stop;
    bit            p_vld;
    bit            p_par;
    bit            p_stop;

    always #5 clk = ~clk;

    rx_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .RX_P_DATA    (rx_data),
        .RX_DATA_VALID(rx_vld),
        .RX_PAR_ERR   (rx_par),
        .RX_STOP_ERR  (rx_stop),
        .RD_EN        (rd_en),
        .CLR_ERR      (clr_err),
        .RD_DATA      (rd_data),
        .RD_VALID     (rd_valid),
        .FIFO_FULL    (fifo_full),
        .FIFO_COUNT   (fifo_count),
        .OVERRUN      (overrun),
        .PAR_ERR_CNT  (par_cnt),
        .STOP_ERR_CNT (stop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr  = 1'b0;
        m_par  = 0;
        m_stop = 0;
        p_vld  = 1'b0;
        p_par  = 1'b0;
        p_stop = 1'b0;
    endtask

    task automatic model_step();
        bit good;
        bit popped;
        bit dropped;
        good    = rx_vld && !p_vld && !rx_par && !rx_stop;
        popped  = rd_en && (q.size() != 0);
        dropped = good && (q.size() == DEPTH) && !popped;
        if (popped) void'(q.pop_front());
        if (good && !dropped) q.push_back(rx_data);
        if (clr_err) begin
            m_ovr  = 1'b0;
            m_par  = 0;
            m_stop = 0;
        end
        if (dropped) m_ovr = 1'b1;
        if (rx_par && !p_par)   m_par  = (m_par  >= CMAX) ? CMAX : m_par + 1;
        if (rx_stop && !p_stop) m_stop = (m_stop >= CMAX) ? CMAX : m_stop + 1;
        p_vld  = rx_vld;
        p_par  = rx_par;
        p_stop = rx_stop;
    endtask

    task automatic check_all();
        chk("rd_valid",   32'(rd_valid),   32'(q.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("fifo_full",  32'(fifo_full),  32'(q.size() == DEPTH));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("par_cnt",    32'(par_cnt),    32'(m_par));
        chk("stop_cnt",   32'(stop_cnt),   32'(m_stop));
        if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic frame(input logic [DW-1:0] d, input bit par, input bit stop, input int hold);
        rx_data = d;
        rx_vld  = 1'b1;
        rx_par  = par;
        rx_stop = stop;
        repeat (hold) cycle();
        rx_vld  = 1'b0;
        rx_par  = 1'b0;
        rx_stop = 1'b0;
        cycle();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rd_valid"},   32'(rd_valid),   0);
        chk({tag, "_fifo_full"},  32'(fifo_full),  0);
        chk({tag, "_fifo_count"}, 32'(fifo_count), 0);
        chk({tag, "_overrun"},    32'(overrun),    0);
        chk({tag, "_par_cnt"},    32'(par_cnt),    0);
        chk({tag, "_stop_cnt"},   32'(stop_cnt),   0);
        chk({tag, "_rd_data"},    32'(rd_data),    0);
    endtask

    initial begin
        rst_n   = 1'b1;
        rx_data = '0;
        rx_vld  = 1'b0;
        rx_par  = 1'b0;
        rx_stop = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) cycle();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        cycle();

        // Two frames with valid held three cycles each, then drain.
        frame(8'hA5, 1'b0, 1'b0, 3);
        chk("r35_cnt_after_a5", 32'(fifo_count), 1);
        frame(8'h3C, 1'b0, 1'b0, 3);
        chk("r35_cnt_after_3c", 32'(fifo_count), 2);
        chk("r35_head_a5", 32'(rd_data), 32'h A5);
        pop_one();
        chk("r35_cnt_after_pop1", 32'(fifo_count), 1);
        chk("r35_head_3c", 32'(rd_data), 32'h3C);
        pop_one();
        chk("r35_cnt_after_pop2", 32'(fifo_count), 0);
        chk("r35_empty", 32'(rd_valid), 0);

        // Nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) frame(DW'(i), 1'b0, 1'b0, 1);
        chk("r36_full", 32'(fifo_full), 1);
        chk("r36_overrun", 32'(overrun), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("r36_pop_data", 32'(rd_data), 32'(i));
            pop_one();
        end
        chk("r36_drained", 32'(rd_valid), 0);
        chk("r36_overrun_sticky", 32'(overrun), 1);

        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        chk("clr_overrun", 32'(overrun), 0);

        // Full FIFO accepts a frame when a pop lands in the same cycle.
        for (int i = 0; i < 8; i++) frame(DW'(8'h10 + i), 1'b0, 1'b0, 1);
        chk("r37_full_before", 32'(fifo_full), 1);
        rx_data = 8'h55;
        rx_vld  = 1'b1;
        rd_en   = 1'b1;
        cycle();
        rd_en   = 1'b0;
        rx_vld  = 1'b0;
        cycle();
        chk("r37_cnt_stays_8", 32'(fifo_count), 8);
        chk("r37_no_overrun", 32'(overrun), 0);
        repeat (7) pop_one();
        chk("r37_last_is_55", 32'(rd_data), 32'h55);
        pop_one();
        chk("r37_drained", 32'(rd_valid), 0);

        // Bad frame with both errors, then parity saturation.
        frame(8'h77, 1'b1, 1'b1, 2);
        chk("r38_not_written", 32'(fifo_count), 0);
        chk("r38_par_1", 32'(par_cnt), 1);
        chk("r38_stop_1", 32'(stop_cnt), 1);
        repeat (300) begin
            rx_par = 1'b1;
            cycle();
            rx_par = 1'b0;
            cycle();
        end
        chk("r38_par_sat", 32'(par_cnt), 255);
        chk("r38_stop_still_1", 32'(stop_cnt), 1);

        // Clear coincident with a parity rising edge.
        frame(8'h21, 1'b0, 1'b0, 1);
        frame(8'h22, 1'b0, 1'b0, 1);
        clr_err = 1'b1;
        rx_par  = 1'b1;
        cycle();
        clr_err = 1'b0;
        rx_par  = 1'b0;
        cycle();
        chk("r39_par_1", 32'(par_cnt), 1);
        chk("r39_stop_0", 32'(stop_cnt), 0);
        chk("r39_overrun_0", 32'(overrun), 0);
        chk("r39_cnt_kept", 32'(fifo_count), 2);

        // Randomized traffic: light reads first so the FIFO fills, then heavier reads.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 1) == 0) rx_vld = ~rx_vld;
            rx_data = DW'($urandom);
            rx_par  = ($urandom_range(0, 9) == 0);
            rx_stop = ($urandom_range(0, 9) == 0);
            rd_en   = (n < 300) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            clr_err = ($urandom_range(0, 39) == 0);
            cycle();
        end
        rx_vld  = 1'b0;
        rx_par  = 1'b0;
        rx_stop = 1'b0;
        clr_err = 1'b0;
        rd_en   = 1'b1;
        repeat (10) cycle();
        rd_en   = 1'b0;

        // Reset mid-operation with valid held high through release.
        for (int i = 0; i < 3; i++) frame(DW'(8'hB0 + i), 1'b0, 1'b0, 1);
        chk("r40_stored_3", 32'(fifo_count), 3);
        rx_data = 8'hC4;
        rx_vld  = 1'b1;
        rst_n   = 1'b0;
        #1;
        model_reset();
        check_zero_outputs("r40_async");
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("r40_one_frame", 32'(fifo_count), 1);
        chk("r40_data", 32'(rd_data), 32'hC4);
        cycle();
        rx_vld = 1'b0;
        cycle();
        chk("r40_no_dup", 32'(fifo_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
